mem_port_ctrl: RTL
==================

MEM_PORT_CTRL -- requirements
Module: mem_port_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, giving the data word width.
REQ-002 The block SHALL have parameter ADDR_W, default 8, giving the address width.
REQ-003 The block SHALL have parameter MEM_DEPTH, default 128, giving the number of valid words; legal addresses are 0..MEM_DEPTH-1.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port req_valid, input, 1 bit: the requester presents a request.
REQ-007 The block SHALL have port req_ready, output, 1 bit: the block accepts a request this cycle.
REQ-008 The block SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-009 The block SHALL have port req_addr, input, ADDR_W bits: the word address.
REQ-010 The block SHALL have port req_wdata, input, DATA_W bits: the store data.
REQ-011 The block SHALL have port rsp_valid, output, 1 bit: a response is pending.
REQ-012 The block SHALL have port rsp_ready, input, 1 bit: the requester consumes the response.
REQ-013 The block SHALL have port rsp_rdata, output, DATA_W bits: load data; 0 for stores and errors.
REQ-014 The block SHALL have port rsp_err, output, 1 bit: the request address is out of range.
REQ-015 The block SHALL have port mem_addr, output, ADDR_W bits, driven to the SRAM address port.
REQ-016 The block SHALL have port mem_din, output, DATA_W bits, driven to the SRAM write data port.
REQ-017 The block SHALL have port mem_we, output, 1 bit, driven to the SRAM write enable; the SRAM writes on the clk rising edge when mem_we=1.
REQ-018 The block SHALL have port mem_dout, input, DATA_W bits: SRAM read data, combinational from mem_addr while mem_we=0.

Function
REQ-019 The FSM SHALL have the states IDLE, WRITE, READ, RESP and ERR, held in registers.
REQ-020 req_ready SHALL be 1 only in IDLE; a request is accepted on an edge where req_valid=1 and req_ready=1.
REQ-021 On acceptance the block SHALL latch req_we, req_addr and req_wdata; later changes on the req_* inputs SHALL have no effect until the next acceptance.
REQ-022 On acceptance with latched address >= MEM_DEPTH, the next state SHALL be ERR, and the SRAM SHALL NOT be accessed.
REQ-023 On acceptance with a legal address, the next state SHALL be WRITE if req_we=1, otherwise READ.
REQ-024 In WRITE: mem_we=1, mem_addr = latched address, mem_din = latched data, for exactly one cycle; the next state SHALL be RESP with rsp_rdata=0 and rsp_err=0.
REQ-025 In READ: mem_we=0, mem_addr = latched address; at the end of the cycle the block SHALL register mem_dout into rsp_rdata; the next state SHALL be RESP with rsp_err=0.
REQ-026 In ERR: the block SHALL load rsp_rdata=0 and rsp_err=1, and the next state SHALL be RESP.
REQ-027 In RESP: rsp_valid=1; rsp_rdata and rsp_err SHALL be stable until the edge where rsp_ready=1, after which the state SHALL be IDLE.
REQ-028 Latency for a legal request SHALL be: acceptance at edge k, then rsp_valid=1 from edge k+2.
REQ-029 Latency for an error request SHALL be: rsp_valid=1 from edge k+2, passing through ERR for one cycle.
REQ-030 Throughput SHALL be at most one request per 3 cycles; a new acceptance SHALL occur no earlier than the cycle after the response handshake.
REQ-031 Outside WRITE, mem_we SHALL be 0.
REQ-032 mem_we SHALL be combinationally gated by ~rst, so no SRAM write occurs on a reset cycle.
REQ-033 mem_addr and mem_din SHALL hold the last latched values outside WRITE and READ (no glitch to X).
REQ-034 Illegal or unreachable state encodings SHALL return to IDLE on the next edge.

Reset
REQ-035 While rst=1 at a rising edge, the state SHALL become IDLE, and the latched address, latched data, rsp_rdata and rsp_err SHALL become 0.
REQ-036 After reset, outputs SHALL be: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_addr=0, mem_din=0, mem_we=0.
REQ-037 A reset asserted in WRITE, READ, ERR or RESP SHALL abort the operation with no response delivered and no SRAM write in the reset cycle.

Verification
REQ-038 Store then load: store addr 0x05 data 0xBEEF, then load 0x05 -> mem_we=1 for exactly one cycle, the store response has rsp_err=0 and rsp_rdata=0x0000, and the load response has rsp_rdata=0xBEEF at edge k+2.
REQ-039 Out of range: load addr 0x80 (128) -> mem_we stays 0, mem_addr unchanged, and the response has rsp_err=1 and rsp_rdata=0x0000; boundary addr 0x7F is legal.
REQ-040 Backpressure: hold rsp_ready=0 for 5 cycles after a load of 0x7F (pre-stored as 0x1234) -> rsp_valid=1 and rsp_rdata=0x1234 held stable and req_ready=0 throughout; req_ready=1 on the cycle after the handshake.
REQ-041 Input isolation: change req_addr and req_wdata the cycle after acceptance of a store to 0x10 with 0xAAAA -> mem[0x10]=0xAAAA, and no other address is modified.
REQ-042 Reset in WRITE: assert rst during the WRITE cycle of a store of 0x5555 to 0x20 (previously 0x0000) -> mem[0x20] remains 0x0000, there is no rsp_valid, and all outputs hold the REQ-036 values.
REQ-043 Back-to-back: 4 stores followed by 4 loads with rsp_ready tied to 1 -> each response arrives exactly 2 edges after its acceptance, with accepts every 3 cycles and data returned in order.

Source files
------------

// File: rtl/mem_port_ctrl.sv
// Single-port SRAM request/response controller: accepts one load or store at a
// time, range-checks the address and returns a registered response.
module mem_port_ctrl #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_dout
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        RESP  = 3'd3,
        ERR   = 3'd4
    } state_t;

    state_t state, state_next;

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              accept;
    logic              addr_bad;

    assign accept   = req_valid && (state == IDLE);
    assign addr_bad = 32'(req_addr) >= MEM_DEPTH;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (addr_bad) begin
                        state_next = ERR;
                    end else if (req_we) begin
                        state_next = WRITE;
                    end else begin
                        state_next = READ;
                    end
                end
            end
            WRITE, READ, ERR: state_next = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Out-of-range requests never touch the SRAM port, so the port registers
    // only capture legal requests and otherwise keep their previous values.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            data_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept && !addr_bad) begin
                addr_q <= req_addr;
                data_q <= req_wdata;
            end
            case (state)
                WRITE: begin
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                end
                READ: begin
                    rdata_q <= mem_dout;
                    err_q   <= 1'b0;
                end
                ERR: begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign mem_addr  = addr_q;
    assign mem_din   = data_q;
    assign mem_we    = (state == WRITE) && !rst;

endmodule
